// File: rtl/gpioemu_job_sequencer.sv
// gpioemu_job_sequencer
//
// Bus master for the GPIO-emulated multiply/popcount peripheral. It takes one
// operand pair at a time from a valid/ready stream. For each pair it writes A1,
// A2 and START. It then polls STATUS until the peripheral reports done, reads
// back W (product[31:0]) and L (ones count), and presents the result on a
// valid/ready result stream.
//
// Ports
//   clk, reset            single clock, asynchronous active-high reset
//   in_valid/in_ready     operand stream handshake
//   in_a1, in_a2          24-bit operands
//   out_valid/out_ready   result stream handshake (result held until taken)
//   out_w                 product[31:0] read from ADDR_W
//   out_ones              ones count, L[5:0]
//   out_ovf               product did not fit in 32 bits
//   out_timeout           STATUS never reported done within POLL_MAX reads
//   saddress, sdata_in    bus address / write data towards the peripheral
//   swr, srd              registered write / read strobes
//   sdata_out             bus read data from the peripheral
//   job_count             completed jobs (timeouts included), wraps at 16 bits
//
// Every bus access takes three cycles: setup, strobe, hold. Read data is
// sampled on the clock edge that ends the hold cycle. The edge that accepts a
// job does not drive the bus. The first setup appears one cycle later. STATUS
// bit1 is "done" and bit0 is "product fits in 32 bits".

module gpioemu_job_sequencer #(
    parameter logic [15:0] ADDR_A1   = 16'h0380,
    parameter logic [15:0] ADDR_A2   = 16'h0388,
    parameter logic [15:0] ADDR_W    = 16'h0390,
    parameter logic [15:0] ADDR_L    = 16'h0398,
    parameter logic [15:0] ADDR_CTRL = 16'h03A0,
    parameter int unsigned POLL_MAX  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_a1,
    input  logic [23:0] in_a2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [5:0]  out_ones,
    output logic        out_ovf,
    output logic        out_timeout,
    output logic [15:0] saddress,
    output logic [31:0] sdata_in,
    output logic        swr,
    output logic        srd,
    input  logic [31:0] sdata_out,
    output logic [15:0] job_count
);

    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L, OUT
    } state_t;

    // PH_LAUNCH is the quiet cycle right after a job is accepted; the first
    // setup cycle follows it.
    typedef enum logic [1:0] {
        PH_SETUP, PH_STROBE, PH_HOLD, PH_LAUNCH
    } phase_t;

    state_t         state_q;
    state_t         next_state_d;
    state_t         acc_state;
    phase_t         ph_q;
    logic [23:0]    a1_q;
    logic [23:0]    a2_q;
    logic [PW-1:0]  poll_cnt_q;
    logic [PW-1:0]  poll_cnt_d;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [31:0]    out_w_q;
    logic [5:0]     out_ones_q;
    logic           out_ovf_q;
    logic           out_timeout_q;
    logic [15:0]    saddress_q;
    logic [31:0]    sdata_in_q;
    logic           swr_q;
    logic           srd_q;
    logic [15:0]    job_count_q;
    logic [15:0]    job_count_d;
    logic [15:0]    acc_addr;
    logic [31:0]    acc_data;
    logic           acc_write;

    // This block chooses the state that follows the current bus access. Only
    // the value seen at the end of the hold cycle matters. In POLL,
    // poll_cnt_d already includes the read that is finishing now. A timeout
    // therefore fires right after the POLL_MAX-th STATUS read.
    always_comb begin
        poll_cnt_d   = poll_cnt_q + PW'(1);
        job_count_d  = job_count_q + 16'd1;
        next_state_d = state_q;
        case (state_q)
            WR_A1:   next_state_d = WR_A2;
            WR_A2:   next_state_d = WR_GO;
            WR_GO:   next_state_d = POLL;
            POLL: begin
                if (sdata_out[1]) begin
                    next_state_d = RD_W;
                end else if (poll_cnt_d == PW'(POLL_MAX)) begin
                    next_state_d = OUT;
                end else begin
                    next_state_d = POLL;
                end
            end
            RD_W:    next_state_d = RD_L;
            RD_L:    next_state_d = OUT;
            default: next_state_d = state_q;
        endcase
    end

    // This block decodes address, data and direction for a bus access. On the
    // hold edge the next access is set up, so it decodes the upcoming state.
    // Otherwise it decodes the current state. Reads always drive zero data.
    always_comb begin
        acc_state = (ph_q == PH_HOLD) ? next_state_d : state_q;
        acc_addr  = 16'h0000;
        acc_data  = 32'h0000_0000;
        acc_write = 1'b0;
        case (acc_state)
            WR_A1: begin
                acc_addr  = ADDR_A1;
                acc_data  = {8'h00, a1_q};
                acc_write = 1'b1;
            end
            WR_A2: begin
                acc_addr  = ADDR_A2;
                acc_data  = {8'h00, a2_q};
                acc_write = 1'b1;
            end
            WR_GO: begin
                acc_addr  = ADDR_CTRL;
                acc_data  = 32'h0000_0001;
                acc_write = 1'b1;
            end
            POLL:    acc_addr = ADDR_CTRL;
            RD_W:    acc_addr = ADDR_W;
            RD_L:    acc_addr = ADDR_L;
            default: acc_addr = 16'h0000;
        endcase
    end

    // This is the main sequencer. All outputs, including the strobes, are
    // registers here, so they never glitch and swr/srd are never high
    // together. A reset in the middle of a job clears everything at once. The
    // job in flight produces no result and does not increment job_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ph_q          <= PH_SETUP;
            a1_q          <= '0;
            a2_q          <= '0;
            poll_cnt_q    <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_w_q       <= '0;
            out_ones_q    <= '0;
            out_ovf_q     <= 1'b0;
            out_timeout_q <= 1'b0;
            saddress_q    <= '0;
            sdata_in_q    <= '0;
            swr_q         <= 1'b0;
            srd_q         <= 1'b0;
            job_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a1_q       <= in_a1;
                        a2_q       <= in_a2;
                        in_ready_q <= 1'b0;
                        state_q    <= WR_A1;
                        ph_q       <= PH_LAUNCH;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        job_count_q <= job_count_d;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    case (ph_q)
                        PH_LAUNCH: begin
                            saddress_q <= acc_addr;
                            sdata_in_q <= acc_data;
                            ph_q       <= PH_SETUP;
                        end
                        PH_SETUP: begin
                            swr_q <= acc_write;
                            srd_q <= ~acc_write;
                            ph_q  <= PH_STROBE;
                        end
                        PH_STROBE: begin
                            swr_q <= 1'b0;
                            srd_q <= 1'b0;
                            ph_q  <= PH_HOLD;
                        end
                        default: begin
                            case (state_q)
                                WR_GO: poll_cnt_q <= '0;
                                POLL: begin
                                    poll_cnt_q <= poll_cnt_d;
                                    if (sdata_out[1]) begin
                                        out_ovf_q <= ~sdata_out[0];
                                    end else if (next_state_d == OUT) begin
                                        out_w_q       <= '0;
                                        out_ones_q    <= '0;
                                        out_ovf_q     <= 1'b0;
                                        out_timeout_q <= 1'b1;
                                    end
                                end
                                RD_W: out_w_q <= sdata_out;
                                RD_L: begin
                                    out_ones_q    <= sdata_out[5:0];
                                    out_timeout_q <= 1'b0;
                                end
                                default: ;
                            endcase
                            state_q <= next_state_d;
                            if (next_state_d == OUT) begin
                                saddress_q  <= '0;
                                sdata_in_q  <= '0;
                                out_valid_q <= 1'b1;
                            end else begin
                                saddress_q <= acc_addr;
                                sdata_in_q <= acc_data;
                                ph_q       <= PH_SETUP;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_w       = out_w_q;
    assign out_ones    = out_ones_q;
    assign out_ovf     = out_ovf_q;
    assign out_timeout = out_timeout_q;
    assign saddress    = saddress_q;
    assign sdata_in    = sdata_in_q;
    assign swr         = swr_q;
    assign srd         = srd_q;
    assign job_count   = job_count_q;

endmodule

// File: tb/tb_gpioemu_job_sequencer.sv
// tb_gpioemu_job_sequencer
//
// Testbench for gpioemu_job_sequencer. It contains a behavioural model of the
// multiply/popcount peripheral and a result scoreboard. The directed sequence
// pushes the expected result when it drives each job. A monitor pops and
// compares each result when the DUT hands it over.

module tb_gpioemu_job_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_a1;
    logic [23:0] in_a2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic [5:0]  out_ones;
    logic        out_ovf;
    logic        out_timeout;
    logic [15:0] saddress;
    logic [31:0] sdata_in;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [15:0] job_count;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  ones;
        logic        ovf;
        logic        tmo;
        int          acceptCyc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   jobsDone    = 0;
    int   statusReads = 0;
    bit   stuck       = 1'b0;
    bit   seenValid   = 1'b0;
    bit   hsPrev      = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gpioemu_job_sequencer #(.POLL_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a1      (in_a1),
        .in_a2      (in_a2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_w      (out_w),
        .out_ones   (out_ones),
        .out_ovf    (out_ovf),
        .out_timeout(out_timeout),
        .saddress   (saddress),
        .sdata_in   (sdata_in),
        .swr        (swr),
        .srd        (srd),
        .sdata_out  (sdata_out),
        .job_count  (job_count)
    );

    // Peripheral model. It latches writes and updates read data on any clock
    // edge that sees a strobe high. After START it reports done four clocks
    // later. In stuck mode STATUS always reads 2'b01 (never done).
    logic [23:0] pA1 = '0;
    logic [23:0] pA2 = '0;
    logic [47:0] pProd = '0;
    int          pBusy = 0;

    initial sdata_out = '0;

    always @(posedge clk) begin
        if (swr) begin
            case (saddress)
                16'h0380: pA1 <= sdata_in[23:0];
                16'h0388: pA2 <= sdata_in[23:0];
                16'h03A0: begin
                    pProd <= {24'h0, pA1} * {24'h0, pA2};
                    pBusy <= 4;
                end
                default: ;
            endcase
        end else if (pBusy > 0) begin
            pBusy <= pBusy - 1;
        end
        if (srd) begin
            case (saddress)
                16'h03A0: sdata_out <= stuck ? 32'h1 :
                                       {30'h0, pBusy == 0, pProd[47:32] == 16'h0};
                16'h0390: sdata_out <= pProd[31:0];
                16'h0398: sdata_out <= 32'($countones(pProd[31:0]));
                default:  sdata_out <= 32'hDEAD_BEEF;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t makeExp(input logic [23:0] a1, input logic [23:0] a2,
                                     input int k, input bit tmo, input int acc);
        exp_t        e;
        logic [47:0] p;
        p = {24'h0, a1} * {24'h0, a2};
        e.w         = tmo ? 32'h0 : p[31:0];
        e.ones      = tmo ? 6'd0 : 6'($countones(p[31:0]));
        e.ovf       = tmo ? 1'b0 : (p[47:32] != 16'h0);
        e.tmo       = tmo;
        e.acceptCyc = acc;
        e.lat       = tmo ? (10 + 3 * k) : (16 + 3 * k);
        return e;
    endfunction

    // Drives one job and pushes its expected result. It is called just after
    // a rising edge and returns just after the accepting edge.
    task automatic applyStimulus(input logic [23:0] a1, input logic [23:0] a2,
                                 input int k, input bit tmo);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_wait", in_ready, 1);
        in_a1    = a1;
        in_a2    = a2;
        in_valid = 1'b1;
        sbq.push_back(makeExp(a1, a2, k, tmo, cyc + 1));
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 300) begin
            tick(1);
            guard++;
        end
        checkOutput("result_pending", sbq.size(), 0);
        tick(2);
    endtask

    // Result monitor, sampled on the falling edge. It checks the latency when
    // out_valid rises and the full result plus job_count at the handshake. It
    // also checks that out_valid drops right after the handshake.
    always @(negedge clk) begin
        if (reset) begin
            seenValid = 1'b0;
            hsPrev    = 1'b0;
        end else begin
            if (hsPrev) checkOutput("valid_drop", out_valid, 0);
            hsPrev = 1'b0;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_result", out_valid, 0);
                end else begin
                    if (!seenValid) checkOutput("latency", cyc - sbq[0].acceptCyc, sbq[0].lat);
                    seenValid = 1'b1;
                    if (out_ready) begin
                        checkOutput("out_w", out_w, sbq[0].w);
                        checkOutput("out_ones", out_ones, sbq[0].ones);
                        checkOutput("out_ovf", out_ovf, sbq[0].ovf);
                        checkOutput("out_timeout", out_timeout, sbq[0].tmo);
                        checkOutput("job_count_pre", job_count, jobsDone & 16'hFFFF);
                        void'(sbq.pop_front());
                        jobsDone++;
                        seenValid = 1'b0;
                        hsPrev    = 1'b1;
                    end
                end
            end
        end
    end

    // Bus monitor: counts STATUS reads and flags any cycle with both strobes.
    always @(negedge clk) begin
        if (srd && saddress == 16'h03A0) statusReads++;
        if (swr && srd) checkOutput("strobe_exclusive", {swr, srd}, 2'b10);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [15:0] eA [7];
    logic [31:0] eD [7];
    bit          eW [7];
    logic [49:0] eb;
    int          j;
    int          p;
    int          base;
    int          guard;
    bit          anyValid;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a1     = '0;
        in_a2     = '0;
        out_ready = 1'b1;

        // Values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_bus", {saddress, sdata_in, swr, srd}, 50'h0);
        checkOutput("reset_out", {in_ready, out_valid, out_w, out_ones, out_ovf, out_timeout}, 42'h0);
        checkOutput("reset_job_count", job_count, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        checkOutput("in_ready_after_reset", in_ready, 1);

        // Job 1 (3*5), checking the bus cycle by cycle.
        eA = '{16'h0380, 16'h0388, 16'h03A0, 16'h03A0, 16'h03A0, 16'h0390, 16'h0398};
        eD = '{32'h3, 32'h5, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        eW = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(24'h000003, 24'h000005, 2, 1'b0);
        for (int n = 0; n < 22; n++) begin
            if (n == 0) begin
                eb = '0;
            end else begin
                j  = (n - 1) / 3;
                p  = (n - 1) % 3;
                eb = {eA[j], eD[j], (p == 1) && eW[j], (p == 1) && !eW[j]};
            end
            checkOutput($sformatf("bus_n%0d", n), {saddress, sdata_in, swr, srd}, eb);
            tick(1);
        end
        waitIdle();
        checkOutput("job_count_1", job_count, 1);

        // Largest operands: overflow, low word FE000001.
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 2, 1'b0);
        waitIdle();

        // STATUS stuck at 2'b01: four STATUS reads, then a timeout result.
        stuck       = 1'b1;
        statusReads = 0;
        applyStimulus(24'h000007, 24'h000009, 4, 1'b0 | 1'b1);
        waitIdle();
        checkOutput("status_reads", statusReads, 4);
        stuck = 1'b0;

        // Backpressure: hold out_ready low 10 cycles with in_valid asserted.
        out_ready = 1'b0;
        applyStimulus(24'h001234, 24'h000567, 2, 1'b0);
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick(1);
            guard++;
        end
        in_valid = 1'b1;
        in_a1    = 24'hABCDEF;
        in_a2    = 24'h000011;
        for (int n = 0; n < 10; n++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_w", out_w, sbq[0].w);
            checkOutput("hold_ones", out_ones, sbq[0].ones);
            checkOutput("hold_in_ready", in_ready, 0);
            tick(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitIdle();

        // Three back-to-back jobs, including an exact 2^32 product.
        base = jobsDone;
        applyStimulus(24'h123456, 24'h00ABCD, 2, 1'b0);
        applyStimulus(24'h800000, 24'h000200, 2, 1'b0);
        applyStimulus(24'hFFFFFF, 24'h000100, 2, 1'b0);
        waitIdle();
        checkOutput("job_count_btb", job_count, base + 3);

        // Reset pulse during the WR_A2 strobe.
        applyStimulus(24'h00000B, 24'h00000D, 2, 1'b0);
        tick(5);
        checkOutput("swr_before_reset", {swr, saddress}, {1'b1, 16'h0388});
        #2;
        reset = 1'b1;
        #1;
        checkOutput("swr_at_reset", {swr, srd, saddress}, 18'h0);
        sbq.delete();
        jobsDone = 0;
        tick(2);
        checkOutput("job_count_after_reset", job_count, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        anyValid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            anyValid = anyValid | out_valid;
            tick(1);
        end
        checkOutput("no_result_after_abort", anyValid, 0);
        applyStimulus(24'h000011, 24'h000013, 2, 1'b0);
        waitIdle();
        checkOutput("job_count_after_abort", job_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
